// File: rtl/pair_cover_scheduler_if.sv
// ---------------------------------------------------------------------------
// pair_cover_scheduler_if
// Bundles the requester-side and result-side signals of the pair coverage
// scheduler.
//   req_valid  [NREQ]        per-requester request
//   req_a      [NREQ*PAIRS]  operand A, requester k owns [k*PAIRS +: PAIRS]
//   req_b      [NREQ*PAIRS]  operand B, same slicing as req_a
//   req_grant  [NREQ]        one-hot grant pulse; operands captured on it
//   resp_valid               one-cycle result strobe
//   resp_id    [IDW]         requester that owns the result
//   resp_cover               1 = every pair covered
//   busy                     engine is scanning or presenting a result
// master: the requester/consumer side.  slave: the scheduler.
// ---------------------------------------------------------------------------
interface pair_cover_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int PAIRS = 16
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*PAIRS-1:0] req_a;
   logic [NREQ*PAIRS-1:0] req_b;
   logic [NREQ-1:0]       req_grant;
   logic                  resp_valid;
   logic [IDW-1:0]        resp_id;
   logic                  resp_cover;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b,
      input  req_grant, resp_valid, resp_id, resp_cover, busy
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_grant, resp_valid, resp_id, resp_cover, busy
   );
endinterface

// File: rtl/pair_cover_scheduler.sv
// ---------------------------------------------------------------------------
// pair_cover_scheduler
// Shared sequential pair-coverage engine.  A round-robin arbiter picks one of
// NREQ requesters, its PAIRS operand pairs are captured and reduced LANES
// pairs per cycle, and the engine reports whether every pair (a[i] | b[i])
// is set.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pair_cover_scheduler_if.slave (request, grant and result signals)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; grant is driven combinationally here only
// SCAN  | reducing LANES pairs per cycle from the captured shift registers
// DONE  | resp_valid strobe with the accumulated result, then back to IDLE
// ---------------------------------------------------------------------------
module pair_cover_scheduler #(
   parameter int NREQ       = 4,
   parameter int PAIRS      = 16,
   parameter int LANES      = 4,
   parameter int EARLY_EXIT = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   pair_cover_scheduler_if.slave bus
);

   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BEATS = PAIRS / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [IDW-1:0]   rr_last;
   logic             acc;
   logic [BW-1:0]    beat;
   logic [PAIRS-1:0] sa;
   logic [PAIRS-1:0] sb;
   logic             resp_valid_q;
   logic [IDW-1:0]   resp_id_q;
   logic             resp_cover_q;

   logic             found;
   logic [IDW-1:0]   pick;
   logic [IDW-1:0]   cand;
   logic [NREQ-1:0]  grant;
   logic             lane_and;
   logic             last_beat;

   // Round-robin search starting just above the last winner.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(rr_last) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Grant is held off while reset is applied so nothing is captured then.
   always_comb begin
      grant = '0;
      if (rst_n && (state == ST_IDLE) && found) begin
         grant[pick] = 1'b1;
      end
   end

   assign lane_and  = &(sa[LANES-1:0] | sb[LANES-1:0]);
   assign last_beat = (beat == BW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         rr_last      <= IDW'(NREQ - 1);
         acc          <= 1'b1;
         beat         <= '0;
         sa           <= '0;
         sb           <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_cover_q <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  sa      <= bus.req_a[int'(pick)*PAIRS +: PAIRS];
                  sb      <= bus.req_b[int'(pick)*PAIRS +: PAIRS];
                  rr_last <= pick;
                  acc     <= 1'b1;
                  beat    <= '0;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               acc  <= acc & lane_and;
               sa   <= sa >> LANES;
               sb   <= sb >> LANES;
               beat <= beat + BW'(1);
               // The result register is loaded on the way into DONE so the
               // strobe lines up with the DONE cycle.
               if (last_beat || ((EARLY_EXIT != 0) && !lane_and)) begin
                  state        <= ST_DONE;
                  resp_valid_q <= 1'b1;
                  resp_cover_q <= acc & lane_and;
                  resp_id_q    <= rr_last;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_grant  = grant;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_cover = resp_cover_q;
   assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_pair_cover_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pair_cover_scheduler
// Two instances share operands: dut_e scans with early exit, dut_f always
// scans every beat.  Expected grants, latencies and covers come from a
// behavioural model of the arbitration order and pair coverage rules.
// ---------------------------------------------------------------------------
module tb_pair_cover_scheduler;

   localparam int NREQ     = 4;
   localparam int PAIRS    = 16;
   localparam int LANES    = 4;
   localparam int BEATS    = PAIRS / LANES;
   localparam int FULL_LAT = BEATS + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n;
   logic [NREQ-1:0]       val_e;
   logic [NREQ-1:0]       val_f;
   logic [NREQ*PAIRS-1:0] op_a;
   logic [NREQ*PAIRS-1:0] op_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rr_e     = NREQ - 1;
   int rr_f     = NREQ - 1;

   pair_cover_scheduler_if #(.NREQ(NREQ), .PAIRS(PAIRS)) bus_e ();
   pair_cover_scheduler_if #(.NREQ(NREQ), .PAIRS(PAIRS)) bus_f ();

   assign bus_e.req_valid = val_e;
   assign bus_e.req_a     = op_a;
   assign bus_e.req_b     = op_b;
   assign bus_f.req_valid = val_f;
   assign bus_f.req_a     = op_a;
   assign bus_f.req_b     = op_b;

   pair_cover_scheduler #(.NREQ(NREQ), .PAIRS(PAIRS), .LANES(LANES), .EARLY_EXIT(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .bus(bus_e));
   pair_cover_scheduler #(.NREQ(NREQ), .PAIRS(PAIRS), .LANES(LANES), .EARLY_EXIT(0)) dut_f (
      .clk(clk), .rst_n(rst_n), .bus(bus_f));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Model: next winner searching upward from rr+1, -1 if nobody asks.
   function automatic int arb(input int rr, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
      end
      return -1;
   endfunction

   // Model: cycles from grant to resp_valid.
   function automatic int exp_lat(input logic [PAIRS-1:0] a, input logic [PAIRS-1:0] b,
                                  input bit ee);
      for (int i = 0; i < PAIRS; i++) begin
         if ((a[i] | b[i]) !== 1'b1) return ee ? (i / LANES) + 2 : BEATS + 1;
      end
      return BEATS + 1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_ops(input int w, input logic [PAIRS-1:0] a, input logic [PAIRS-1:0] b);
      op_a[w*PAIRS +: PAIRS] = a;
      op_b[w*PAIRS +: PAIRS] = b;
   endtask

   task automatic gen_ops(input int w);
      logic [PAIRS-1:0] a, b, m;
      int mode;
      a    = PAIRS'($urandom);
      mode = $urandom_range(0, 2);
      m    = PAIRS'(1) << $urandom_range(0, PAIRS - 1);
      case (mode)
         0:       b = ~a;
         1:       begin a = a & ~m; b = ~a & ~m; end
         default: b = PAIRS'($urandom);
      endcase
      set_ops(w, a, b);
   endtask

   // Waits for a grant on dut_e (and dut_f when on_f), then follows the
   // request to its result strobe and compares against the model.
   task automatic serve(input bit on_f, input bit keep, input logic [NREQ-1:0] raise,
                        input string tag, output int t_grant);
      int w_e, w_f, lat_e, lat_f, got_e, got_f, n;
      bit seen;
      logic cov_exp, cov_e, cov_f;
      logic [1:0] id_e, id_f;
      logic [PAIRS-1:0] a, b;
      seen = 1'b0; n = 0; t_grant = -1;
      cov_e = 1'b0; cov_f = 1'b0; id_e = '0; id_f = '0;
      while (!seen && n < 40) begin
         #1;
         if (bus_e.req_grant !== '0) seen = 1'b1;
         else begin step(); n++; end
      end
      chk({tag, "_grant_seen"}, 32'(seen), 32'd1);
      if (!seen) return;
      w_e = arb(rr_e, val_e);
      chk({tag, "_grant_e"}, 32'(bus_e.req_grant), 32'(onehot(w_e)));
      if (w_e < 0) return;
      if (on_f) begin
         w_f = arb(rr_f, val_f);
         chk({tag, "_grant_f"}, 32'(bus_f.req_grant), 32'(onehot(w_f)));
         if (w_f >= 0) rr_f = w_f;
      end
      rr_e    = w_e;
      t_grant = cyc;
      a       = op_a[w_e*PAIRS +: PAIRS];
      b       = op_b[w_e*PAIRS +: PAIRS];
      lat_e   = exp_lat(a, b, 1'b1);
      lat_f   = exp_lat(a, b, 1'b0);
      cov_exp = &(a | b);
      got_e = -1; got_f = -1;
      for (int k = 1; k <= FULL_LAT + 2; k++) begin
         step();
         if (k == 1) begin
            chk({tag, "_busy"}, 32'(bus_e.busy), 32'd1);
            if (!keep) begin
               val_e[w_e] = 1'b0;
               val_f[w_e] = 1'b0;
               set_ops(w_e, PAIRS'($urandom), PAIRS'($urandom));
            end
            val_e = val_e | raise;
         end
         if (got_e < 0 && bus_e.resp_valid === 1'b1) begin
            got_e = k; cov_e = bus_e.resp_cover; id_e = bus_e.resp_id;
         end
         if (on_f && got_f < 0 && bus_f.resp_valid === 1'b1) begin
            got_f = k; cov_f = bus_f.resp_cover; id_f = bus_f.resp_id;
         end
         if (got_e >= 0 && (!on_f || got_f >= 0)) break;
      end
      chk({tag, "_lat_e"}, 32'(got_e), 32'(lat_e));
      chk({tag, "_cover_e"}, 32'(cov_e), 32'(cov_exp));
      chk({tag, "_id_e"}, 32'(id_e), 32'(w_e));
      if (on_f) begin
         chk({tag, "_lat_f"}, 32'(got_f), 32'(lat_f));
         chk({tag, "_cover_f"}, 32'(cov_f), 32'(cov_exp));
         chk({tag, "_id_f"}, 32'(id_f), 32'(w_e));
         step();
      end
   endtask

   initial begin
      int t, t_prev, w;
      logic [NREQ-1:0] mask;

      rst_n = 1'b0; val_e = '0; val_f = '0; op_a = '0; op_b = '0;
      step(); step();
      chk("rst_grant", 32'(bus_e.req_grant), 32'd0);
      chk("rst_resp_valid", 32'(bus_e.resp_valid), 32'd0);
      chk("rst_resp_id", 32'(bus_e.resp_id), 32'd0);
      chk("rst_resp_cover", 32'(bus_e.resp_cover), 32'd0);
      chk("rst_busy", 32'(bus_e.busy), 32'd0);
      chk("rst_busy_f", 32'(bus_f.busy), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed single requests on both instances.
      set_ops(0, 16'hFFFF, 16'h0000); val_e = 4'b0001; val_f = 4'b0001;
      serve(1'b1, 1'b0, '0, "req0_full", t);
      set_ops(2, 16'hDFFF, 16'h0000); val_e = 4'b0100; val_f = 4'b0100;
      serve(1'b1, 1'b0, '0, "pair13", t);
      set_ops(2, 16'hFFFE, 16'h0000); val_e = 4'b0100; val_f = 4'b0100;
      serve(1'b1, 1'b0, '0, "pair0", t);
      set_ops(1, 16'hAAAA, 16'h5555); val_e = 4'b0010; val_f = 4'b0010;
      serve(1'b1, 1'b0, '0, "compl", t);
      set_ops(1, 16'hAAAA, 16'h1555); val_e = 4'b0010; val_f = 4'b0010;
      serve(1'b1, 1'b0, '0, "compl_gap", t);

      // Fairness: all requesters held from reset release.
      rst_n = 1'b0;
      for (int k = 0; k < NREQ; k++) set_ops(k, 16'hFFFF, 16'h0000);
      val_e = '1;
      step();
      rst_n = 1'b1; rr_e = NREQ - 1; rr_f = NREQ - 1;
      t_prev = -1;
      for (int g = 0; g < 5; g++) begin
         serve(1'b0, 1'b1, '0, "fair", t);
         if (g > 0) chk("fair_spacing", 32'(t - t_prev), 32'(BEATS + 2));
         t_prev = t;
      end
      val_e = '0;
      step();

      // Requests raised while req 1 is being scanned.
      set_ops(1, 16'h0F0F, 16'hF0F0); set_ops(0, 16'h1234, 16'hFFFF);
      set_ops(3, 16'h00FF, 16'hFF7F);
      val_e = 4'b0010;
      serve(1'b0, 1'b0, 4'b1001, "raise_a", t);
      serve(1'b0, 1'b0, '0, "raise_b", t);
      serve(1'b0, 1'b0, '0, "raise_c", t);
      step();

      // Reset during SCAN beat 2.
      set_ops(1, 16'hFFFF, 16'h0000); val_e = 4'b0010;
      serve(1'b0, 1'b0, '0, "pre_rst", t);
      step();
      set_ops(1, 16'hFFFF, 16'h0000); set_ops(2, 16'hFFFF, 16'h0000);
      val_e = 4'b0110;
      #1;
      chk("abort_grant", 32'(bus_e.req_grant), 32'(onehot(arb(rr_e, val_e))));
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; rr_e = NREQ - 1; rr_f = NREQ - 1;
      chk("abort_busy", 32'(bus_e.busy), 32'd0);
      chk("abort_resp_valid", 32'(bus_e.resp_valid), 32'd0);
      serve(1'b0, 1'b0, '0, "post_rst_a", t);
      serve(1'b0, 1'b0, '0, "post_rst_b", t);

      // Randomized traffic: single requests on both, contended on dut_e.
      for (int r = 0; r < 40; r++) begin
         step();
         if ($urandom_range(0, 1) == 0) begin
            w = $urandom_range(0, NREQ - 1);
            for (int k = 0; k < NREQ; k++) gen_ops(k);
            val_e[w] = 1'b1; val_f[w] = 1'b1;
            serve(1'b1, 1'b0, '0, "rnd_single", t);
         end else begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) gen_ops(k);
            val_e = mask;
            for (int g = 0; g < NREQ && val_e != '0; g++) begin
               serve(1'b0, 1'b0, '0, "rnd_multi", t);
            end
            val_e = '0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pair_cover_scheduler.md
Name: pair_cover_scheduler

Overview:
- Shared, sequential pair-coverage engine. Each request supplies PAIRS operand pairs (a[i], b[i]); the engine answers whether every pair is covered, i.e. AND over i of (a[i] | b[i]).
- Replaces one wide combinational OR-AND tree per group with a single LANES-wide reduction slice, time-multiplexed between NREQ requesters under round-robin arbitration.
- Sits between the group-status sources and the coverage flags consumer; one result per granted request.

Parameters:
- NREQ, 4, number of requesters; must be >= 2.
- PAIRS, 16, operand pairs per request.
- LANES, 4, pairs reduced per scan cycle; PAIRS must be a multiple of LANES.
- EARLY_EXIT, 1, 1 = stop scanning as soon as an uncovered pair is found.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ*PAIRS  operand A; requester k uses slice [k*PAIRS +: PAIRS].
- req_b  in  NREQ*PAIRS  operand B; same slicing as req_a.
- req_grant  out  NREQ  one-hot, one-cycle pulse; operands are captured on this edge.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  max(1,clog2(NREQ))  index of the requester that owns the result.
- resp_cover  out  1  1 = all PAIRS pairs covered.
- busy  out  1  high in SCAN and DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: req_grant=0, resp_valid=0, resp_id=0, resp_cover=0, busy=0, state=IDLE, rr_last=NREQ-1 (requester 0 has first priority), acc=1, beat=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If any req_valid is high, req_grant is asserted combinationally for the first valid requester found searching upward from rr_last+1, modulo NREQ.
  - On that edge: capture the granted slices into shift registers sa/sb, set rr_last=winner, acc=1, beat=0, go to SCAN.
  - With no request, stay in IDLE.
- Requester protocol: hold valid and operands stable until granted. Dropping valid before the grant is legal and has no effect.
- SCAN, each cycle:
  - acc <= acc & AND(sa[LANES-1:0] | sb[LANES-1:0]).
  - Shift sa and sb right by LANES; beat++.
  - Go to DONE when beat reaches PAIRS/LANES-1, or, when EARLY_EXIT=1, when this cycle's lane reduction is 0.
- DONE:
  - Drive resp_valid=1 for one cycle, with resp_cover=acc and resp_id=winner.
  - Return to IDLE.
  - resp_cover and resp_id hold their values until the next DONE.
- req_grant is never asserted outside IDLE. Requests arriving during SCAN or DONE wait.
- Latency:
  - With the grant at cycle t, resp_valid is high at t+PAIRS/LANES+1 (t+5 with defaults).
  - Early exit on beat j (0-based) gives resp_valid at t+j+2.
  - Minimum grant-to-grant spacing is PAIRS/LANES+2 cycles.
- Lane order: lanes 0..LANES-1 are scanned first; pair i is evaluated on beat floor(i/LANES).
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,... No requester waits more than NREQ-1 other grants.
- Reset asserted mid-SCAN or mid-DONE: the next cycle is IDLE with reset values and no resp_valid. The aborted request is not remembered and must be re-presented.
- X/garbage on the req_a/req_b slices of non-granted requesters has no effect.

Test Plan:
- Req 0 only, a=16'hFFFF, b=0, grant at t -> req_grant=4'b0001 at t; resp_valid at t+5, resp_cover=1, resp_id=0.
- Req 2, a=16'hDFFF, b=16'h0000 (pair 13 uncovered), EARLY_EXIT=1, grant at t -> uncovered on beat 3; resp_valid at t+5, resp_cover=0, resp_id=2. Same stimulus with a=16'hFFFE (pair 0 uncovered) -> resp_valid at t+2, resp_cover=0. Same stimulus with EARLY_EXIT=0 -> resp_valid at t+5, resp_cover=0.
- Complementary operands a=16'hAAAA, b=16'h5555 on req 1 -> resp_cover=1; a=16'hAAAA, b=16'h1555 -> resp_cover=0.
- All four requests valid and held from reset release -> grants in order 0,1,2,3,0, spaced 6 cycles apart; resp_id follows the same order.
- After req 1 is granted, raise req 0 and req 3 -> req 3 is granted next, then req 0.
- Assert rst_n=0 for one cycle during SCAN beat 2 -> no resp_valid; busy=0 the next cycle; a held request is re-granted starting with requester 0 priority.
